// File: rtl/sample_writer.sv
// Commits packed 64-bit ADC sample words to the capture RAM through a small FIFO
// and a waitrequest-style write port; one capture per arm pulse, fixed word count.
module sample_writer #(
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_W        = 14,
    parameter int CAPTURE_WORDS = 16384
) (
    input  logic              i_50clk,
    input  logic              i_nreset,
    input  logic              i_arm,
    input  logic [63:0]       i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic [63:0]       o_writedata,
    output logic [7:0]        o_byteen,
    output logic              o_write,
    input  logic              i_waitrequest,
    output logic              o_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_count
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] CAP_WORDS = (ADDR_W + 1)'(CAPTURE_WORDS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [63:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic [ADDR_W:0]   push_count_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_inc;
    logic              overflow_reg;

    logic        capturing;
    logic        start;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push_want;
    logic        push;
    logic        drop;
    logic        write_req;
    logic        pop;
    logic        last_pop;
    logic [63:0] fifo_head;
    logic [63:0] head_masked;

    assign capturing  = (state_reg == ST_CAPTURE);
    assign start      = i_arm && !capturing;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // Words beyond the capture length are ignored, not counted as lost.
    assign push_want = capturing && i_valid && (push_count_reg < CAP_WORDS);
    assign push      = push_want && !fifo_full;
    assign drop      = push_want && fifo_full;
    assign write_req = capturing && !fifo_empty;
    assign pop       = write_req && !i_waitrequest;
    assign count_inc = count_reg + 1'b1;
    assign last_pop  = pop && (count_inc == CAP_WORDS);

    assign fifo_head = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign head_masked[16*gi +: 16] = fifo_head[16*gi +: 16] & 16'h3FFF;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (i_arm) state_next = ST_CAPTURE;
            ST_CAPTURE: if (last_pop) state_next = ST_DONE;
            ST_DONE:    if (i_arm) state_next = ST_CAPTURE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_50clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_50clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            push_count_reg <= '0;
            address_reg    <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                push_count_reg <= '0;
                address_reg    <= '0;
                count_reg      <= '0;
                overflow_reg   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                    push_count_reg <= push_count_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                    address_reg <= address_reg + 1'b1;
                    count_reg   <= count_inc;
                end
                if (drop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign o_ready     = !capturing || !fifo_full;
    assign o_write     = write_req;
    assign o_writedata = write_req ? head_masked : 64'h0;
    assign o_byteen    = write_req ? 8'hFF : 8'h00;
    assign o_address   = address_reg;
    assign o_count     = count_reg;
    assign o_done      = (state_reg == ST_DONE);
    assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_sample_writer.sv
// Directed bench for sample_writer with a 16-word capture and an 8-deep FIFO.
module tb_sample_writer;

    logic        clk;
    logic        rst_n;
    logic        i_arm;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [13:0] o_address;
    logic [63:0] o_writedata;
    logic [7:0]  o_byteen;
    logic        o_write;
    logic        i_waitrequest;
    logic        o_done;
    logic        o_overflow;
    logic [14:0] o_count;

    int checks;
    int failures;

    sample_writer #(
        .FIFO_DEPTH   (8),
        .ADDR_W       (14),
        .CAPTURE_WORDS(16)
    ) dut (
        .i_50clk      (clk),
        .i_nreset     (rst_n),
        .i_arm        (i_arm),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_address    (o_address),
        .o_writedata  (o_writedata),
        .o_byteen     (o_byteen),
        .o_write      (o_write),
        .i_waitrequest(i_waitrequest),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_arm = 1'b0; i_data = '0; i_valid = 1'b0; i_waitrequest = 1'b0;
        repeat (3) step();
        checks++; if (o_write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", o_write); end
        checks++; if (o_byteen !== 8'h00) begin failures++; $display("FAIL reset_byteen: got %h expected 00", o_byteen); end
        checks++; if (o_address !== 14'd0) begin failures++; $display("FAIL reset_address: got %0d expected 0", o_address); end
        checks++; if (o_writedata !== 64'h0) begin failures++; $display("FAIL reset_writedata: got %h expected 0", o_writedata); end
        checks++; if (o_count !== 15'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        checks++; if (o_done !== 1'b0 || o_overflow !== 1'b0) begin failures++; $display("FAIL reset_flags: got done=%b ovf=%b expected 0 0", o_done, o_overflow); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        rst_n = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int nw = 0;
        int last_wr = -10;
        logic done_seen = 1'b0;
        logic [13:0] exp_addr;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        checks++; if (o_done !== 1'b0 || o_count !== 15'd0) begin failures++; $display("FAIL basic_arm: got done=%b count=%0d expected 0 0", o_done, o_count); end
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (i < 16) begin i_valid = 1'b1; i_data = 64'(i); end
            else begin i_valid = 1'b0; i_data = '0; end
            step();
            if (o_write === 1'b1) begin
                exp_addr = 14'(nw);
                checks++; if (o_address !== exp_addr) begin failures++; $display("FAIL basic_addr: got %0d expected %0d", o_address, exp_addr); end
                checks++; if (o_writedata !== 64'(nw)) begin failures++; $display("FAIL basic_data: got %h expected %h", o_writedata, 64'(nw)); end
                checks++; if (o_byteen !== 8'hFF) begin failures++; $display("FAIL basic_byteen: got %h expected FF", o_byteen); end
                nw++; last_wr = i;
            end
            if (o_done === 1'b1) begin
                done_seen = 1'b1;
                checks++; if (last_wr !== i - 1) begin failures++; $display("FAIL basic_done_latency: last write iter %0d expected %0d", last_wr, i - 1); end
            end
        end
        i_valid = 1'b0;
        checks++; if (!done_seen) begin failures++; $display("FAIL basic_done_timeout: got done=0 expected 1"); end
        checks++; if (nw !== 16) begin failures++; $display("FAIL basic_writes: got %0d expected 16", nw); end
        checks++; if (o_count !== 15'd16) begin failures++; $display("FAIL basic_count: got %0d expected 16", o_count); end
        checks++; if (o_overflow !== 1'b0 || o_write !== 1'b0 || o_byteen !== 8'h00) begin failures++; $display("FAIL basic_end: got ovf=%b write=%b byteen=%h expected 0 0 00", o_overflow, o_write, o_byteen); end
        $display("test_basic: %0d writes", nw);
    endtask

    task automatic test_pad();
        int nw = 0;
        logic done_seen = 1'b0;
        logic [63:0] exp_data;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (i < 16) begin
                i_valid = 1'b1;
                i_data = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_4000_C000_1234;
            end else begin
                i_valid = 1'b0; i_data = '0;
            end
            step();
            if (o_write === 1'b1) begin
                exp_data = (nw % 2 == 0) ? 64'h3FFF_3FFF_3FFF_3FFF : 64'h0000_0000_0000_1234;
                checks++; if (o_writedata !== exp_data) begin failures++; $display("FAIL pad_data: word %0d got %h expected %h", nw, o_writedata, exp_data); end
                nw++;
            end
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        i_valid = 1'b0;
        checks++; if (!done_seen || nw !== 16) begin failures++; $display("FAIL pad_end: got done=%b writes=%0d expected 1 16", done_seen, nw); end
        $display("test_pad: %0d writes", nw);
    endtask

    task automatic test_stall();
        logic [13:0] exp_addr;
        i_waitrequest = 1'b1;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        for (int j = 0; j < 20; j++) begin
            i_valid = 1'b1; i_data = 64'(100 + j);
            step();
            checks++; if (o_write !== 1'b1 || o_address !== 14'd0) begin failures++; $display("FAIL stall_hold_addr: cycle %0d got write=%b addr=%0d expected 1 0", j, o_write, o_address); end
            checks++; if (o_writedata !== 64'd100) begin failures++; $display("FAIL stall_hold_data: cycle %0d got %h expected %h", j, o_writedata, 64'd100); end
        end
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", o_ready); end
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL stall_overflow: got %b expected 1", o_overflow); end
        checks++; if (o_count !== 15'd0) begin failures++; $display("FAIL stall_count: got %0d expected 0", o_count); end
        i_waitrequest = 1'b0;
        for (int n = 0; n < 8; n++) begin
            exp_addr = 14'(n);
            checks++; if (o_write !== 1'b1 || o_address !== exp_addr) begin failures++; $display("FAIL stall_drain_addr: got write=%b addr=%0d expected 1 %0d", o_write, o_address, exp_addr); end
            checks++; if (o_writedata !== 64'(100 + n)) begin failures++; $display("FAIL stall_drain_data: got %h expected %h", o_writedata, 64'(100 + n)); end
            step();
        end
        checks++; if (o_write !== 1'b0 || o_count !== 15'd8) begin failures++; $display("FAIL stall_drained: got write=%b count=%0d expected 0 8", o_write, o_count); end
        for (int m = 0; m < 8; m++) begin
            i_valid = 1'b1; i_data = 64'(200 + m);
            step();
            exp_addr = 14'(8 + m);
            checks++; if (o_write !== 1'b1 || o_address !== exp_addr || o_writedata !== 64'(200 + m)) begin
                failures++; $display("FAIL stall_resume: got write=%b addr=%0d data=%h expected 1 %0d %h", o_write, o_address, o_writedata, exp_addr, 64'(200 + m));
            end
        end
        i_valid = 1'b0;
        step();
        checks++; if (o_done !== 1'b1 || o_count !== 15'd16 || o_overflow !== 1'b1 || o_write !== 1'b0) begin
            failures++; $display("FAIL stall_end: got done=%b count=%0d ovf=%b write=%b expected 1 16 1 0", o_done, o_count, o_overflow, o_write);
        end
        $display("test_stall: done=%b count=%0d", o_done, o_count);
    endtask

    task automatic test_limit();
        int nw = 0;
        logic done_seen = 1'b0;
        logic [13:0] exp_addr;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        checks++; if (o_count !== 15'd0 || o_overflow !== 1'b0 || o_done !== 1'b0 || o_address !== 14'd0) begin
            failures++; $display("FAIL rearm_clear: got count=%0d ovf=%b done=%b addr=%0d expected 0 0 0 0", o_count, o_overflow, o_done, o_address);
        end
        for (int i = 0; i < 30 && !done_seen; i++) begin
            i_valid = (i < 20); i_data = 64'(300 + i);
            step();
            if (o_write === 1'b1) begin
                exp_addr = 14'(nw);
                checks++; if (o_address !== exp_addr || o_writedata !== 64'(300 + nw)) begin
                    failures++; $display("FAIL limit_write: got addr=%0d data=%h expected %0d %h", o_address, o_writedata, exp_addr, 64'(300 + nw));
                end
                nw++;
            end
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        checks++; if (nw !== 16 || !done_seen) begin failures++; $display("FAIL limit_writes: got writes=%0d done=%b expected 16 1", nw, done_seen); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL limit_overflow: got %b expected 0", o_overflow); end
        i_valid = 1'b1;
        repeat (3) step();
        i_valid = 1'b0;
        checks++; if (o_count !== 15'd16 || o_write !== 1'b0 || o_done !== 1'b1) begin
            failures++; $display("FAIL limit_hold: got count=%0d write=%b done=%b expected 16 0 1", o_count, o_write, o_done);
        end
        $display("test_limit: %0d writes", nw);
    endtask

    task automatic test_arm_ignored();
        int nw = 0;
        logic done_seen = 1'b0;
        logic [13:0] exp_addr;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        for (int i = 0; i < 30 && !done_seen; i++) begin
            i_valid = (i < 16); i_data = 64'(400 + i);
            i_arm = (i == 5);
            step();
            if (o_write === 1'b1) begin
                exp_addr = 14'(nw);
                checks++; if (o_address !== exp_addr || o_writedata !== 64'(400 + nw)) begin
                    failures++; $display("FAIL arm_ignored_write: got addr=%0d data=%h expected %0d %h", o_address, o_writedata, exp_addr, 64'(400 + nw));
                end
                nw++;
            end
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        i_arm = 1'b0; i_valid = 1'b0;
        checks++; if (nw !== 16 || !done_seen || o_count !== 15'd16) begin
            failures++; $display("FAIL arm_ignored_end: got writes=%0d done=%b count=%0d expected 16 1 16", nw, done_seen, o_count);
        end
        $display("test_arm_ignored: %0d writes", nw);
    endtask

    task automatic test_reset_mid();
        i_arm = 1'b1; step(); i_arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1; i_data = 64'(500 + i);
            step();
        end
        i_valid = 1'b0;
        step();
        i_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = 64'(600 + i);
            step();
        end
        i_valid = 1'b0;
        checks++; if (o_write !== 1'b1 || o_address !== 14'd5 || o_count !== 15'd5) begin
            failures++; $display("FAIL midreset_pre: got write=%b addr=%0d count=%0d expected 1 5 5", o_write, o_address, o_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_write !== 1'b0 || o_address !== 14'd0 || o_count !== 15'd0) begin
            failures++; $display("FAIL midreset_async: got write=%b addr=%0d count=%0d expected 0 0 0", o_write, o_address, o_count);
        end
        checks++; if (o_ready !== 1'b1 || o_byteen !== 8'h00 || o_writedata !== 64'h0) begin
            failures++; $display("FAIL midreset_outputs: got ready=%b byteen=%h data=%h expected 1 00 0", o_ready, o_byteen, o_writedata);
        end
        i_waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_data = 64'(700 + i);
            step();
            checks++; if (o_write !== 1'b0 || o_done !== 1'b0 || o_address !== 14'd0) begin
                failures++; $display("FAIL midreset_idle: got write=%b done=%b addr=%0d expected 0 0 0", o_write, o_done, o_address);
            end
        end
        i_valid = 1'b0;
        $display("test_reset_mid: idle addr=%0d", o_address);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_pad();
        test_stall();
        test_limit();
        test_arm_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
